// File: rtl/rotate_pkg.sv
// Shared rotate helpers: FSM state type, rotate-amount width helper and a
// combinational right rotate reused by the loopback benches.
package rotate_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } rot_state_t;

  // Widest operand the shared rotate function handles.
  localparam int unsigned ROT_MAX_W = 64;

  // Rotate-amount width for a given operand width (at least one bit).
  function automatic int unsigned shamt_width(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

  // Right rotate of the low 'width' bits of value by amt; upper bits read 0.
  function automatic logic [ROT_MAX_W-1:0] rotr(input logic [ROT_MAX_W-1:0] value,
                                                input int unsigned          amt,
                                                input int unsigned          width);
    logic [ROT_MAX_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < ROT_MAX_W; i++) begin
      if (i < width) begin
        res[i] = value[(i + amt) % width];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/left_rotate_seq.sv
// Iterative left rotator: captures an operand and rotate amount, rotates left
// one bit per clock, then registers the result with a one-cycle valid pulse.
// Optional feature macro: LEFT_ROTATE_CHECK_EN -- rotates the final value back
// to the right and raises check alongside valid when it matches the operand.
module left_rotate_seq
  import rotate_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = shamt_width(WIDTH)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] amount,
  output logic               ready,
  output logic [WIDTH-1:0]   result,
  output logic               valid,
  output logic               check
);

  rot_state_t         state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               valid_q, valid_d;
  logic               check_d;

`ifdef LEFT_ROTATE_CHECK_EN
  logic [WIDTH-1:0]     orig_q, orig_d;
  logic [SHAMT_W-1:0]   amt_q, amt_d;
  logic                 check_q;
  logic [ROT_MAX_W-1:0] unrot;
  logic                 self_ok;

  // Undo the rotation of the final value and compare with the captured operand.
  always_comb begin
    unrot   = rotr(ROT_MAX_W'(shreg_q), 32'(amt_q), unsigned'(WIDTH));
    self_ok = (unrot == ROT_MAX_W'(orig_q));
  end
`endif

  assign ready  = (state_q == IDLE);
  assign result = result_q;
  assign valid  = valid_q;

  // Next-state, shift register, counter and output register logic.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = 1'b0;
    check_d  = 1'b0;
`ifdef LEFT_ROTATE_CHECK_EN
    orig_d   = orig_q;
    amt_d    = amt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = data_in;
          cnt_d   = amount;
`ifdef LEFT_ROTATE_CHECK_EN
          orig_d  = data_in;
          amt_d   = amount;
`endif
          // A zero rotate skips straight to presenting the operand.
          state_d = (amount == '0) ? DONE : ROTATE;
        end
      end
      ROTATE: begin
        shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
        cnt_d   = cnt_q - SHAMT_W'(1);
        // cnt==1 means this cycle takes the final shift.
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        result_d = shreg_q;
        valid_d  = 1'b1;
`ifdef LEFT_ROTATE_CHECK_EN
        check_d  = self_ok;
`endif
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

`ifdef LEFT_ROTATE_CHECK_EN
  // Self-check registers: operand copy, captured amount and check flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      orig_q  <= '0;
      amt_q   <= '0;
      check_q <= 1'b0;
    end else begin
      orig_q  <= orig_d;
      amt_q   <= amt_d;
      check_q <= check_d;
    end
  end

  assign check = check_q;
`else
  assign check = 1'b0;
`endif

endmodule
